cdc_fifo_gray_drain: RTL and testbench

Single-clock read-end controller for a gray-pointer CDC FIFO whose writer exposes its storage array and gray write pointer asynchronously. It synchronizes the write pointer and maintains the gray read pointer returned to the writer. It presents words on a registered valid/ready stream and adds features the plain reader lacks: occupancy level, almost-empty flag, single-cycle flush (discard) and a dropped-word counter. It sits in the destination domain wherever a consumer must purge stale data, e.g. on a link restart.

---
 rtl/cdc_fifo_gray_drain.sv | 112 +++++++++++
 tb/tb_cdc_fifo_gray_drain.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_fifo_gray_drain.sv
// Read-end controller for a gray-pointer CDC FIFO: synchronizes the writer's pointer, drives a
// registered valid/ready stream, and adds occupancy, almost-empty, single-cycle flush and a drop counter.
module cdc_fifo_gray_drain #(
  parameter int WIDTH       = 8,
  parameter int LOG_DEPTH   = 3,
  parameter int SYNC_STAGES = 2,
  parameter int AE_THRESH   = 1,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [WIDTH*(2**LOG_DEPTH)-1:0] async_data_i,
  input  logic [LOG_DEPTH:0]              async_wptr_i,
  output logic [LOG_DEPTH:0]              async_rptr_o,
  output logic [WIDTH-1:0]                data_o,
  output logic                            valid_o,
  input  logic                            ready_i,
  input  logic                            flush_i,
  output logic [LOG_DEPTH+1:0]            level_o,
  output logic                            almost_empty_o,
  output logic [CNT_WIDTH-1:0]            drop_cnt_o
);
  localparam int DEPTH = 2**LOG_DEPTH;
  localparam int PW    = LOG_DEPTH + 1;
  localparam int SUM_W = ((CNT_WIDTH > PW) ? CNT_WIDTH : PW) + 1;
  localparam logic [PW-1:0] FULL = PW'(DEPTH);
  localparam logic [31:0]   AE_U = 32'(AE_THRESH);

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Saturating add: any carry beyond CNT_WIDTH pins the counter at all-ones.
  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] cnt,
                                                   input logic [PW-1:0]        inc);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(cnt) + SUM_W'(inc);
    if (sum[SUM_W-1:CNT_WIDTH] != '0) return '1;
    return sum[CNT_WIDTH-1:0];
  endfunction

  logic [PW-1:0]        sync_q [SYNC_STAGES];
  logic [PW-1:0]        rptr_q, rptr_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic                 valid_q, valid_d;
  logic [CNT_WIDTH-1:0] drop_q, drop_d;
  logic [PW-1:0]        wptr_bin, rptr_bin, ring;
  logic [WIDTH-1:0]     entry [DEPTH];
  logic                 load;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) entry[i] = async_data_i[i*WIDTH +: WIDTH];
  end

  assign wptr_bin = gray2bin(sync_q[SYNC_STAGES-1]);
  assign rptr_bin = gray2bin(rptr_q);
  assign ring     = wptr_bin - rptr_bin;
  assign load     = (ring != '0) && (!valid_q || ready_i) && !flush_i;

  // Flush wins over load; a handshake in the flush cycle still completes because valid drops anyway.
  always_comb begin
    rptr_d  = rptr_q;
    data_d  = data_q;
    valid_d = valid_q;
    drop_d  = drop_q;
    if (flush_i) begin
      rptr_d  = bin2gray(wptr_bin);
      valid_d = 1'b0;
      drop_d  = sat_add(drop_q, ring + PW'(valid_q && !ready_i));
    end else if (load) begin
      data_d  = entry[rptr_bin[LOG_DEPTH-1:0]];
      valid_d = 1'b1;
      rptr_d  = bin2gray(rptr_bin + PW'(1));
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      rptr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      drop_q  <= '0;
    end else begin
      sync_q[0] <= async_wptr_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      rptr_q  <= rptr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
    end
  end

  assign async_rptr_o   = rptr_q;
  assign data_o         = data_q;
  assign valid_o        = valid_q;
  assign drop_cnt_o     = drop_q;
  assign level_o        = {1'b0, ring} + {{PW{1'b0}}, valid_q};
  assign almost_empty_o = (AE_THRESH >= 0) && (32'(level_o) <= AE_U);

  ring_legal: assert property (@(posedge clk_i) disable iff (rst_i) ring <= FULL);

endmodule

// File: tb/tb_cdc_fifo_gray_drain.sv
// Bench for cdc_fifo_gray_drain: a same-clock writer model feeds the ring; a word-queue scoreboard
// tracks delivery order, pointer visibility after synchronization, and flush drop counts.
module tb_cdc_fifo_gray_drain;
  localparam int WIDTH       = 8;
  localparam int LOG_DEPTH   = 3;
  localparam int SYNC_STAGES = 2;
  localparam int AE_THRESH   = 1;
  localparam int CNT_WIDTH   = 3;
  localparam int DEPTH       = 1 << LOG_DEPTH;
  localparam int PW          = LOG_DEPTH + 1;
  localparam int CNT_MAX     = (1 << CNT_WIDTH) - 1;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [WIDTH*DEPTH-1:0] async_data;
  logic [PW-1:0]          async_wptr;
  logic [PW-1:0]          async_rptr;
  logic [WIDTH-1:0]       data;
  logic                   valid;
  logic                   ready;
  logic                   flush;
  logic [LOG_DEPTH+1:0]   level;
  logic                   almost_empty;
  logic [CNT_WIDTH-1:0]   drop_cnt;

  typedef struct {
    logic [WIDTH-1:0] d;
    int               t;
  } word_t;

  word_t            expq[$];
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rseq[$];
  int               wcount, tcount, exp_drop, checks, failures, n, run, maxrun;
  bit               wrap_seen;

  cdc_fifo_gray_drain #(
    .WIDTH(WIDTH), .LOG_DEPTH(LOG_DEPTH), .SYNC_STAGES(SYNC_STAGES),
    .AE_THRESH(AE_THRESH), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk_i(clk), .rst_i(rst), .async_data_i(async_data), .async_wptr_i(async_wptr),
    .async_rptr_o(async_rptr), .data_o(data), .valid_o(valid), .ready_i(ready),
    .flush_i(flush), .level_o(level), .almost_empty_o(almost_empty), .drop_cnt_o(drop_cnt)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) async_data[i*WIDTH +: WIDTH] = mem[i];
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic int gray(input int v);
    return v ^ (v >> 1);
  endfunction

  function automatic int ungray(input logic [PW-1:0] g);
    for (int b = 0; b < 2 * DEPTH; b++) if (PW'(gray(b)) == g) return b;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int space();
    return DEPTH - ((wcount - ungray(async_rptr) + 2 * DEPTH) % (2 * DEPTH));
  endfunction

  task automatic write_word(input logic [WIDTH-1:0] d);
    mem[wcount % DEPTH] = d;
    wcount = (wcount + 1) % (2 * DEPTH);
    async_wptr = PW'(gray(wcount));
    expq.push_back('{d, tcount});
  endtask

  // One clock: settle the scoreboard for the coming edge, then sample after the falling edge.
  task automatic tick();
    logic [PW-1:0] r0;
    int nvis;
    r0 = async_rptr;
    if (!rst) begin
      if (valid && ready) begin
        chk("pop_expected", 64'(expq.size() > 0), 1);
        if (expq.size() > 0) begin
          chk("pop_data", data, expq[0].d);
          void'(expq.pop_front());
        end
      end
      if (flush) begin
        nvis = 0;
        while (nvis < expq.size() && tcount - expq[nvis].t >= SYNC_STAGES) nvis++;
        exp_drop = (exp_drop + nvis > CNT_MAX) ? CNT_MAX : exp_drop + nvis;
        repeat (nvis) void'(expq.pop_front());
      end
    end
    @(posedge clk);
    tcount++;
    @(negedge clk);
    if (!rst && !flush) begin
      chk("gray_one_bit", 64'($countones(r0 ^ async_rptr) <= 1), 1);
      if (r0 == PW'(gray(2 * DEPTH - 1)) && async_rptr == '0) wrap_seen = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ready = 1'b0;
    flush = 1'b0;
    wcount = 0;
    async_wptr = '0;
    expq.delete();
    exp_drop = 0;
    #1;
    chk("rst_valid", valid, 0);
    chk("rst_rptr", async_rptr, 0);
    chk("rst_level", level, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_data", data, 0);
    chk("rst_ae", almost_empty, 1);
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    checks = 0; failures = 0; tcount = 0; exp_drop = 0; wrap_seen = 1'b0;
    rst = 1'b1; ready = 1'b0; flush = 1'b0; wcount = 0; async_wptr = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    @(negedge clk);
    do_reset();

    // reset in the middle of a stream
    ready = 1'b1;
    write_word(8'hA1); tick();
    write_word(8'hA2); tick();
    write_word(8'hA3); tick();
    ready = 1'b0;
    tick();
    do_reset();

    // ordering and gray stepping
    ready = 1'b1;
    rseq.delete();
    rseq.push_back(async_rptr);
    run = 0; maxrun = 0;
    for (int i = 0; i < 8; i++) begin
      if (i < 3) write_word(WIDTH'(17 * (i + 1)));
      tick();
      if (async_rptr != rseq[$]) rseq.push_back(async_rptr);
      run = valid ? run + 1 : 0;
      if (run > maxrun) maxrun = run;
    end
    chk("order_rptr_steps", rseq.size(), 4);
    for (int i = 0; i < 4 && i < rseq.size(); i++) chk("order_rptr_gray", rseq[i], gray(i));
    chk("order_back_to_back", maxrun, 3);
    chk("order_drained", expq.size(), 0);

    // latency of a single word
    write_word(8'h5A); tick();
    chk("lat_pre_level", level, 0);
    tick();
    chk("lat_n_level", level, 1);
    chk("lat_n_valid", valid, 0);
    chk("lat_n_ae", almost_empty, 1);
    tick();
    chk("lat_n1_valid", valid, 1);
    chk("lat_n1_data", data, 8'h5A);
    chk("lat_n1_level", level, 1);
    tick();
    chk("lat_pop_valid", valid, 0);
    chk("lat_pop_level", level, 0);
    chk("lat_pop_ae", almost_empty, 1);

    // backpressure until full: 8 in the ring plus the output register
    ready = 1'b0; n = 0;
    for (int i = 0; i < 60 && n < 9; i++) begin
      if (space() > 0) begin
        write_word(WIDTH'($urandom));
        n++;
      end
      tick();
    end
    repeat (4) tick();
    chk("full_written", n, 9);
    chk("full_level", level, 9);
    chk("full_valid", valid, 1);
    chk("full_head", data, expq[0].d);
    chk("full_ae", almost_empty, 0);
    ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      chk("drain_valid", valid, 1);
      tick();
    end
    chk("drain_level", level, 0);
    chk("drain_valid_end", valid, 0);
    chk("drain_queue", expq.size(), 0);

    // random stream through several pointer wraps
    n = 0; wrap_seen = 1'b0;
    for (int i = 0; i < 3000 && (n < 40 || expq.size() > 0); i++) begin
      ready = (n >= 40) || ($urandom_range(0, 3) != 0);
      if (n < 40 && space() > 0 && $urandom_range(0, 1) == 1) begin
        write_word(WIDTH'($urandom));
        n++;
      end
      tick();
    end
    chk("wrap_words", n, 40);
    chk("wrap_drained", expq.size(), 0);
    chk("wrap_seen", wrap_seen, 1);

    // flush with the head word stalled
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin write_word(WIDTH'($urandom)); tick(); end
    repeat (4) tick();
    chk("flushA_level", level, 5);
    chk("flushA_valid", valid, 1);
    chk("flushA_ae", almost_empty, 0);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flushA_valid_after", valid, 0);
    chk("flushA_level_after", level, 0);
    chk("flushA_drop", drop_cnt, exp_drop);
    chk("flushA_drop_five", exp_drop, 5);
    chk("flushA_ae_after", almost_empty, 1);
    flush = 1'b1; tick(); tick(); flush = 1'b0;
    chk("flush_empty_drop", drop_cnt, exp_drop);

    // almost-empty just above threshold
    for (int i = 0; i < 2; i++) begin write_word(WIDTH'($urandom)); tick(); end
    repeat (4) tick();
    chk("ae2_level", level, 2);
    chk("ae2_flag", almost_empty, 0);
    ready = 1'b1;
    repeat (4) tick();
    chk("ae2_drained", expq.size(), 0);

    do_reset();

    // flush while the head completes, with one word still in the synchronizer
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin write_word(WIDTH'($urandom)); tick(); end
    repeat (4) tick();
    ready = 1'b1; flush = 1'b1;
    write_word(8'hEE);
    tick();
    flush = 1'b0; ready = 1'b0;
    chk("flushB_drop", drop_cnt, exp_drop);
    chk("flushB_drop_four", exp_drop, 4);
    chk("flushB_valid", valid, 0);
    repeat (4) tick();
    chk("flushB_late_level", level, expq.size());
    chk("flushB_late_valid", valid, 1);
    chk("flushB_late_data", data, 8'hEE);
    ready = 1'b1;
    repeat (2) tick();
    chk("flushB_drained", expq.size(), 0);

    // counter saturation
    for (int k = 0; k < 2; k++) begin
      ready = 1'b0;
      for (int i = 0; i < 4; i++) begin write_word(WIDTH'($urandom)); tick(); end
      repeat (4) tick();
      flush = 1'b1; tick(); flush = 1'b0;
      chk("sat_drop", drop_cnt, exp_drop);
    end
    chk("sat_drop_max", drop_cnt, CNT_MAX);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
